// File: rtl/pipe_pkg.sv
// Stage payload types and NOP helpers shared by the inter-stage pipeline registers.
// Consumers build with PIPE_SKID_EN to get the skid-buffered pipe_stage_reg variant.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 160;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned WORD_W      = 32;
   localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      STG_IF_ID   = 2'd0,
      STG_ID_EXE  = 2'd1,
      STG_EXE_MEM = 2'd2,
      STG_MEM_WB  = 2'd3
   } stage_e;

   typedef struct packed {
      logic [WORD_W-1:0] pc4;
      logic [WORD_W-1:0] inst;
   } if_id_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc4;
      logic [WORD_W-1:0] rs_val;
      logic [WORD_W-1:0] rt_val;
      logic [WORD_W-1:0] imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [7:0]        ctrl;
   } id_exe_t;

   typedef struct packed {
      logic [WORD_W-1:0] alu_res;
      logic [WORD_W-1:0] rt_val;
      logic [REG_W-1:0]  dst;
      logic [3:0]        ctrl;
   } exe_mem_t;

   typedef struct packed {
      logic [WORD_W-1:0] alu_res;
      logic [WORD_W-1:0] mem_data;
      logic [REG_W-1:0]  dst;
      logic [1:0]        ctrl;
   } mem_wb_t;

   // Per-stage NOP payload, zero-extended to the generic register width.
   function automatic logic [PIPE_DATA_W-1:0] nop_of(input stage_e stage);
      logic [PIPE_DATA_W-1:0] nop;
      if_id_t                 if_id_nop;
      id_exe_t                id_exe_nop;
      exe_mem_t               exe_mem_nop;
      mem_wb_t                mem_wb_nop;
      nop         = '0;
      if_id_nop   = '0;
      id_exe_nop  = '0;
      exe_mem_nop = '0;
      mem_wb_nop  = '0;
      if_id_nop.inst = NOP_INST;
      case (stage)
         STG_IF_ID:   nop = PIPE_DATA_W'(if_id_nop);
         STG_ID_EXE:  nop = PIPE_DATA_W'(id_exe_nop);
         STG_EXE_MEM: nop = PIPE_DATA_W'(exe_mem_nop);
         STG_MEM_WB:  nop = PIPE_DATA_W'(mem_wb_nop);
         default:     nop = '0;
      endcase
      return nop;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance-debug statistics.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_d;

   // Stick at all-ones instead of wrapping.
   always_comb begin
      value_d = value;
      if (inc && (value != {W{1'b1}})) begin
         value_d = value + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         value <= '0;
      end else begin
         value <= value_d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready, freeze, flush and perf counters.
// Define PIPE_SKID_EN to add a 1-entry skid buffer that cuts the out_ready -> in_ready path.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned        DATA_W    = PIPE_DATA_W,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
   parameter int unsigned        CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              freeze,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              out_valid_q;
   logic              out_valid_d;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] out_data_d;
   logic              in_fire;
   logic              out_fire;
   logic              stall_inc;
   logic              bubble_inc;

`ifdef PIPE_SKID_EN
   logic              skid_valid_q;
   logic              skid_valid_d;
   logic [DATA_W-1:0] skid_data_q;
   logic [DATA_W-1:0] skid_data_d;

   // Registered-only ready: the skid absorbs the beat that arrives while out is blocked.
   assign in_ready = ~skid_valid_q & ~freeze & ~flush;
`else
   assign in_ready = (~out_valid_q | out_ready) & ~freeze & ~flush;
`endif

   assign out_valid = out_valid_q & ~freeze;
   assign out_data  = out_data_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign stall_inc = in_valid & ~in_ready;

   // Next-state: flush beats freeze beats normal handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      bubble_inc  = 1'b0;
`ifdef PIPE_SKID_EN
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
`endif
      if (flush) begin
         out_valid_d = 1'b0;
         out_data_d  = NOP_VALUE;
`ifdef PIPE_SKID_EN
         skid_valid_d = 1'b0;
         skid_data_d  = NOP_VALUE;
`endif
      end else if (!freeze) begin
`ifdef PIPE_SKID_EN
         if (out_fire && skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = NOP_VALUE;
         end else if (in_fire && out_valid_q && !out_ready) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
         end else if (in_fire) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
         end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_data_d  = NOP_VALUE;
            bubble_inc  = 1'b1;
         end
`else
         if (in_fire) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
         end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_data_d  = NOP_VALUE;
            bubble_inc  = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_valid_q <= 1'b0;
         out_data_q  <= NOP_VALUE;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef PIPE_SKID_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= NOP_VALUE;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end
`endif

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (stall_inc),
      .value (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (bubble_inc),
      .value (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;

   localparam int unsigned DW   = 160;
   localparam int unsigned CW   = 6;
   localparam int unsigned CMAX = (1 << CW) - 1;
   localparam logic [DW-1:0] NOP = {5{32'hC0DE_0BAD}};
`ifdef PIPE_SKID_EN
   localparam int unsigned CAP = 2;
`else
   localparam int unsigned CAP = 1;
`endif

   logic          clk;
   logic          rst_b;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          freeze;
   logic          flush;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: payloads held by the stage in arrival order, plus the two statistics.
   logic [DW-1:0] mq[$];
   int unsigned   m_stall;
   int unsigned   m_bub;

   pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .freeze     (freeze),
      .flush      (flush),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_stall = 0;
      m_bub   = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_b = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   // One clock: drive inputs, compare every output with the model, then advance the model.
   task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fz, input logic fl);
      logic          e_rdy, e_ov, ofire, ifire;
      logic [DW-1:0] e_od;
      @(negedge clk);
      in_valid = iv; in_data = d; out_ready = ordy; freeze = fz; flush = fl;
      #1;
      e_ov  = (mq.size() != 0) && !fz;
      e_od  = (mq.size() != 0) ? mq[0] : NOP;
      e_rdy = !fl && !fz && ((mq.size() < CAP) || (CAP == 1 && ordy));
      check("in_ready",   DW'(in_ready),   DW'(e_rdy));
      check("out_valid",  DW'(out_valid),  DW'(e_ov));
      check("out_data",   out_data,        e_od);
      check("stall_cnt",  DW'(stall_cnt),  DW'(m_stall));
      check("bubble_cnt", DW'(bubble_cnt), DW'(m_bub));
      @(posedge clk);
      if (iv && !e_rdy && m_stall < CMAX) m_stall++;
      if (fl) begin
         mq.delete();
      end else if (!fz) begin
         ofire = e_ov && ordy;
         ifire = iv && e_rdy;
         if (ofire) void'(mq.pop_front());
         if (ifire) mq.push_back(d);
         if (ofire && mq.size() == 0 && m_bub < CMAX) m_bub++;
      end
   endtask

   initial begin
      rst_b = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", DW'(out_valid), DW'(1'b0));
      check("rst_out_data",  out_data,       NOP);
      check("rst_stall",     DW'(stall_cnt), '0);
      check("rst_bubble",    DW'(bubble_cnt), '0);
      @(negedge clk);
      rst_b = 1'b1;

      // Streaming 1..8 then drain.
      for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      check("midrst_out_valid", DW'(out_valid),  DW'(1'b0));
      check("midrst_out_data",  out_data,        NOP);
      check("midrst_stall",     DW'(stall_cnt),  '0);
      check("midrst_bubble",    DW'(bubble_cnt), '0);
      do_reset();

      // Freeze holds payload for three cycles while stalls accumulate.
      cyc(1'b1, DW'(8'h5A), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
      #1;
      check("freeze_data",  out_data,       DW'(8'h5A));
      check("freeze_stall", DW'(stall_cnt), DW'(3));

      // Flush wins over freeze and drops the concurrent input.
      cyc(1'b1, rnd_data(), 1'b0, 1'b1, 1'b1);
      #1;
      check("flush_data", out_data, NOP);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Single-beat drain produces one bubble.
      do_reset();
      cyc(1'b1, DW'(8'h11), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain_bubble", DW'(bubble_cnt), DW'(1));

      // Back-pressure: push A, B, C with out_ready low, then release in order.
      do_reset();
      cyc(1'b1, DW'(8'hA0), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, DW'(8'hB0), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, DW'(8'hC0), 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Stall counter saturation under sustained back-pressure.
      cyc(1'b1, DW'(8'hD0), 1'b0, 1'b0, 1'b0);
      repeat (CMAX + 10) cyc(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
      #1;
      check("stall_sat", DW'(stall_cnt), DW'(CMAX));
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b1);

      // Random traffic with occasional freeze and flush.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 9) < 7), rnd_data(), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
